byte_store_buffer: RTL and testbench
====================================

// Module: byte_store_buffer
// PURPOSE
//  Store-side counterpart of the load byte/halfword extractor. It takes sw/sh/sb requests from the MEM stage
//  and checks alignment. Each store becomes a word-aligned address, a 4-bit byte-enable and replicated lane data.
//  Requests are queued in a small FIFO and drained to data memory over a req/ack handshake.
//  Loads that hit a pending store's word are flagged so the hazard unit can stall.
// PARAMETERS
//  DEPTH   2   store-buffer entries (power of two, >=2)
//  AW      32  byte-address width
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  st_valid     in   1    MEM stage presents a store
//  st_op        in   2    store type (ST_NONE/ST_W/ST_H/ST_B)
//  st_addr      in   AW   byte address
//  st_wdata     in   32   rt value (low byte/half used for sb/sh)
//  st_ready     out  1    buffer can accept (!full)
//  st_misalign  out  1    comb: st_valid and address misaligned for st_op
//  ld_valid     in   1    MEM stage presents a load
//  ld_addr      in   AW   load byte address
//  ld_hazard    out  1    comb: load word matches any valid buffer entry
//  mem_req      out  1    head entry presented to memory
//  mem_addr     out  AW   head word address, [1:0]=2'b00
//  mem_wdata    out  32   head lane-replicated data
//  mem_be       out  4    head byte enables
//  mem_ack      in   1    memory accepted head this cycle
//  empty        out  1    no pending stores (for fence/syscall drain)
// BEHAVIOUR
//  - Reset (async assert, sync deassert by caller): count=0, wr/rd ptrs=0, mem_req=0, mem_addr/wdata/be=0,
//    st_ready=1, empty=1. Reset mid-operation discards all queued stores, including a head awaiting ack.
//  - Misalign: ST_W and addr[1:0]!=0, or ST_H and addr[0]=1 -> st_misalign=1. Nothing is enqueued.
//    ST_B never misaligns. ST_NONE is ignored, with st_misalign=0.
//  - Enqueue on the clk edge when st_valid & st_ready & op!=ST_NONE & !st_misalign. When st_ready=0 the request
//    is not taken; MEM must hold it (stall).
//  - Byte enable and data, all values little-endian:
//    - ST_W: be=4'b1111, data=wdata.
//    - ST_H: be = addr[1] ? 4'b1100 : 4'b0011, data={2{wdata[15:0]}}.
//    - ST_B: be=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
//    - Stored addr = {addr[AW-1:2],2'b00}.
//  - Drain: mem_req = !empty, driven straight from registered head storage. The head stays stable until mem_ack.
//    mem_ack while mem_req=0 is ignored. Dequeue happens on the edge where mem_req&mem_ack.
//  - Latency: store accepted at edge N -> mem_req=1 in cycle N+1 at the earliest, when the buffer was empty.
//    With a single-cycle ack, each entry occupies one cycle of memory bandwidth.
//  - Simultaneous enqueue+dequeue: count unchanged and both pointers advance. This is legal when count==DEPTH-1 or
//    lower. When full, st_ready=0 even if mem_ack is high in the same cycle; there is no bypass, so ready timing
//    stays flop-only.
//  - Pointers wrap modulo DEPTH. Full/empty come from the count register (0..DEPTH).
//  - ld_hazard = ld_valid & OR over valid entries of (entry.addr[AW-1:2]==ld_addr[AW-1:2]).
//    The check covers the head being acked this cycle and ignores the store being enqueued this cycle
//    (the pipeline orders that one).
//  - Stores are never merged or reordered; memory sees them in program order.
// STRUCTURE
//  - Shared package mips_mem_pkg: ST_NONE=2'd0, ST_W=2'd1, ST_H=2'd2, ST_B=2'd3; store_entry_t {addr,wdata,be}.
//    The load-extract opcodes also live in this package, so both ends share one encoding.
//  - One natural sub-module, store_lane_gen (combinational): op, addr[1:0], wdata -> be, data, misalign.
//    FIFO, pointers and hazard compare stay in the top module.
// TESTING
//  1. sb addr=0x1003, wdata=0x000000AB -> after 1 cycle mem_req=1, mem_addr=0x1000, be=4'b1000, mem_wdata=0xABABABAB.
//  2. sh addr=0x2002, wdata=0x1234 -> be=4'b1100, mem_wdata=0x12341234. sh addr=0x2001 -> st_misalign=1, empty stays 1.
//  3. Hold mem_ack=0 and issue 3 sw -> st_ready=0 after the 2nd (DEPTH=2), and the 3rd is not taken.
//     Pulse mem_ack -> order 1st, 2nd. The 3rd is accepted on the cycle after ready returns.
//  4. Count=1 with mem_ack=1 and a new sw in the same cycle -> count stays 1 and the new entry becomes head.
//  5. Pending sw to 0x3000, ld_addr=0x3002 -> ld_hazard=1. ld_addr=0x3004 -> ld_hazard=0.
//     ld_valid=0 -> ld_hazard=0.
//  6. Assert reset with 2 entries queued and mem_req=1 -> mem_req=0, empty=1 and st_ready=1 immediately.
//     No mem_ack is needed afterwards.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: opcodes and entry types shared by the load extractor and the store buffer.
package mips_mem_pkg;
    localparam int MEM_AW = 32;
    typedef enum logic [1:0] {ST_NONE = 2'd0, ST_W = 2'd1, ST_H = 2'd2, ST_B = 2'd3} st_op_t;
    typedef enum logic [2:0] {LD_NONE = 3'd0, LD_W = 3'd1, LD_H = 3'd2, LD_HU = 3'd3, LD_B = 3'd4, LD_BU = 3'd5} ld_op_t;
    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } store_entry_t;
endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen: turns a store op and byte offset into byte enables, replicated lane data and a misalign flag.
module store_lane_gen
    import mips_mem_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] data,
    output logic        misalign
);
    assign misalign = (op == ST_W && addr_lo != 2'b00) || (op == ST_H && addr_lo[0]);
    assign be = op == ST_W ? 4'b1111 :
                op == ST_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                op == ST_B ? 4'b0001 << addr_lo : 4'b0000;
    assign data = op == ST_H ? {2{wdata[15:0]}} :
                  op == ST_B ? {4{wdata[7:0]}} : wdata;
endmodule

// File: rtl/byte_store_buffer.sv
// byte_store_buffer: aligns sw/sh/sb stores, queues them in a small FIFO and drains them to memory over req/ack.
module byte_store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = MEM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [1:0]    st_op,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_wdata,
    output logic          st_ready,
    output logic          st_misalign,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);
    store_entry_t  entries [DEPTH];
    store_entry_t  new_entry;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [3:0]    lane_be;
    logic [31:0]   lane_data;
    logic          lane_misalign, push, pop;
    store_lane_gen u_lane (
        .op       (st_op),
        .addr_lo  (st_addr[1:0]),
        .wdata    (st_wdata),
        .be       (lane_be),
        .data     (lane_data),
        .misalign (lane_misalign)
    );
    assign empty       = count == '0;
    assign st_ready    = count != (PW+1)'(DEPTH);
    assign st_misalign = st_valid & lane_misalign;
    assign push        = st_valid & st_ready & (st_op != ST_NONE) & ~lane_misalign;
    assign pop         = ~empty & mem_ack;
    assign new_entry   = '{addr: {st_addr[AW-1:2], 2'b00}, wdata: lane_data, be: lane_be};
    assign mem_req     = ~empty;
    assign mem_addr    = entries[rd_ptr].addr;
    assign mem_wdata   = entries[rd_ptr].wdata;
    assign mem_be      = entries[rd_ptr].be;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= new_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // An entry is live when its distance from the head is below count; this includes a head being acked now.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ld_hazard = ld_hazard | ((count > {1'b0, PW'(i) - rd_ptr}) && entries[i].addr[AW-1:2] == ld_addr[AW-1:2]);
        ld_hazard = ld_hazard & ld_valid;
    end
endmodule

// File: tb/tb_byte_store_buffer.sv
// tb_byte_store_buffer: directed and randomized checks of byte_store_buffer against a queue-based model.
module tb_byte_store_buffer;
    localparam int DEPTH = 2;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0, ld_valid = 1'b0, mem_ack = 1'b0;
    logic [1:0]  st_op = 2'd0;
    logic [31:0] st_addr = '0, st_wdata = '0, ld_addr = '0;
    logic        st_ready, st_misalign, ld_hazard, mem_req, empty;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          n_chk = 0, n_fail = 0;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;
    ent_t q[$];
    byte_store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_ready(st_ready), .st_misalign(st_misalign), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_hazard(ld_hazard), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .empty(empty)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic step(input logic sv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic ack, input logic lv, input logic [31:0] la);
        logic mis, hz, push, pop;
        ent_t e;
        @(negedge clk);
        st_valid = sv; st_op = op; st_addr = a; st_wdata = wd; mem_ack = ack; ld_valid = lv; ld_addr = la;
        #1;
        mis = sv && ((op == 2'd1 && a % 4 != 0) || (op == 2'd2 && a % 2 != 0));
        chk("st_ready", st_ready, q.size() < DEPTH);
        chk("st_misalign", st_misalign, mis);
        chk("empty", empty, q.size() == 0);
        chk("mem_req", mem_req, q.size() != 0);
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_wdata", mem_wdata, q[0].d);
            chk("mem_be", mem_be, q[0].be);
        end
        hz = 1'b0;
        foreach (q[i]) if (lv && (q[i].a >> 2) == (la >> 2)) hz = 1'b1;
        chk("ld_hazard", ld_hazard, hz);
        push = sv && q.size() < DEPTH && op != 2'd0 && !mis;
        pop  = q.size() != 0 && ack;
        e.a  = a - a % 4;
        e.be = op == 2'd1 ? 4'hF : op == 2'd2 ? (a % 4 >= 2 ? 4'hC : 4'h3) : 4'(1 << (a % 4));
        e.d  = op == 2'd1 ? wd : op == 2'd2 ? (wd & 32'hFFFF) * 32'h0001_0001 : (wd & 32'hFF) * 32'h0101_0101;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        #1;
        st_valid = 1'b0; st_op = 2'd0; mem_ack = 1'b0; ld_valid = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 2'd0, 0, 0, 1'b1, 1'b0, 0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", mem_be, 4'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 2'd3, 32'h1003, 32'hAB, 1'b0, 1'b0, 0);
        @(negedge clk); #1;
        chk("sb_req", mem_req, 1'b1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_data", mem_wdata, 32'hABABABAB);
        drain();
        step(1'b1, 2'd2, 32'h2002, 32'h1234, 1'b0, 1'b0, 0);
        @(negedge clk); #1;
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_data", mem_wdata, 32'h12341234);
        drain();
        step(1'b1, 2'd2, 32'h2001, 32'h1234, 1'b0, 1'b0, 0);
        @(negedge clk); #1;
        chk("sh_mis_empty", empty, 1'b1);
        step(1'b1, 2'd1, 32'h5000, 32'h11111111, 1'b0, 1'b0, 0);
        step(1'b1, 2'd1, 32'h5004, 32'h22222222, 1'b0, 1'b0, 0);
        step(1'b1, 2'd1, 32'h5008, 32'h33333333, 1'b0, 1'b0, 0);
        step(1'b1, 2'd1, 32'h5008, 32'h33333333, 1'b1, 1'b0, 0);
        step(1'b1, 2'd1, 32'h5008, 32'h33333333, 1'b0, 1'b0, 0);
        drain();
        step(1'b1, 2'd1, 32'h4000, 32'hA5A5A5A5, 1'b0, 1'b0, 0);
        step(1'b1, 2'd1, 32'h4100, 32'h5A5A5A5A, 1'b1, 1'b0, 0);
        @(negedge clk); #1;
        chk("swap_head", mem_addr, 32'h4100);
        chk("swap_ready", st_ready, 1'b1);
        drain();
        step(1'b1, 2'd1, 32'h3000, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        step(1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 32'h3002);
        step(1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 32'h3004);
        step(1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 32'h3000);
        step(1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 32'h3001);
        step(1'b1, 2'd1, 32'h6000, 32'h1, 1'b0, 1'b0, 0);
        step(1'b1, 2'd3, 32'h6001, 32'h2, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_req", mem_req, 1'b0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_ready", st_ready, 1'b1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 32'h3000 + $urandom_range(0, 15),
                 $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'h3000 + $urandom_range(0, 15));
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
